// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader: streams 32-bit host words LSB-first into a configuration scan chain.
// Define CFG_READBACK_EN to reassemble the chain's shifted-out bits into rd_data words.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 32
) (
  input  logic        prog_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        prog_dout,
  output logic        prog_en,
  input  logic        prog_din,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        rd_valid
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic last;
  // CHAIN_LEN is a multiple of 32, so the low five count bits give the bit position in the word
  assign last = cnt_q[4:0] == 5'd31;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    case (state_q)
      IDLE: state_d = start ? FETCH : IDLE;
      FETCH: if (word_valid) begin
        state_d = SHIFT;
        sh_d = word_data;
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        sh_d = sh_q >> 1;
        if (last) state_d = (cnt_d == CW'(CHAIN_LEN)) ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    if (state_d == IDLE) begin
      cnt_d = '0;
      sh_d = '0;
    end
  end
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
    end
  end
  assign word_ready = state_q == FETCH;
  assign prog_en = state_q == SHIFT;
  assign prog_dout = prog_en & sh_q[0];
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
`ifdef CFG_READBACK_EN
  logic [31:0] rsh_q, rsh_d, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d;
  always_comb begin
    rsh_d = rsh_q;
    rd_data_d = rd_data_q;
    rd_valid_d = 1'b0;
    if (prog_en) begin
      rsh_d = {prog_din, rsh_q[31:1]};
      if (last) begin
        rd_data_d = rsh_d;
        rd_valid_d = 1'b1;
      end
    end
    if (state_d == IDLE) begin
      rsh_d = '0;
      rd_data_d = rd_data_q;
      rd_valid_d = 1'b0;
    end
  end
  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      rsh_q <= '0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rsh_q <= rsh_d;
      rd_data_q <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  logic unused_prog_din;
  assign unused_prog_din = prog_din;
  assign rd_data = '0;
  assign rd_valid = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader: randomized scoreboard bench driving a 64-bit chain model.
module tb_cfg_chain_loader;
  localparam int CL = 64;
  logic prog_clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic word_ready, prog_dout, prog_en, prog_din, busy, done, rd_valid;
  logic [31:0] rd_data;
  logic [CL-1:0] chain_m = '0;
  int checks = 0;
  int errors = 0;
  logic bitq[$];
  logic [CL-1:0] chainq[$];
  logic [31:0] rdq[$];

  cfg_chain_loader #(.CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .rst(rst), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .prog_dout(prog_dout), .prog_en(prog_en), .prog_din(prog_din),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 prog_clk = ~prog_clk;

  // Attached chain: shifts toward bit 0 on enabled edges, bit 0 feeds back as prog_out
  assign prog_din = chain_m[0];
  always @(posedge prog_clk) if (prog_en) chain_m <= {prog_dout, chain_m[CL-1:1]};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush();
    bitq.delete();
    chainq.delete();
    rdq.delete();
  endtask

  always @(negedge prog_clk) if (rst) begin
    if (prog_en) begin
      if (bitq.size() == 0) chk("pending_bits", 64'(bitq.size()), 1);
      else chk("prog_dout", prog_dout, bitq.pop_front());
    end else chk("dout_when_idle", prog_dout, 0);
    if (done) begin
      if (chainq.size() == 0) chk("pending_loads", 64'(chainq.size()), 1);
      else chk("chain_value", chain_m, chainq.pop_front());
`ifndef CFG_READBACK_EN
      chk("readback_off", {rd_valid, rd_data}, 0);
`endif
    end
`ifdef CFG_READBACK_EN
    if (rd_valid) begin
      if (rdq.size() == 0) chk("pending_readback", 64'(rdq.size()), 1);
      else chk("rd_data", rd_data, rdq.pop_front());
    end
`endif
  end

  // ab_word/ab_cyc select the SHIFT cycle to interrupt (ab_word<0: none); rst_hit uses reset instead of abort
  task automatic load(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                      input int ab_word, input int ab_cyc, input bit rst_hit);
    logic [31:0] w;
    @(negedge prog_clk) start = 1'b1;
    @(negedge prog_clk) start = 1'b0;
    chainq.push_back({w1, w0});
`ifdef CFG_READBACK_EN
    rdq.push_back(chain_m[31:0]);
    rdq.push_back(chain_m[63:32]);
`endif
    for (int k = 0; k < 2; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int g = 0; g < gap; g++) begin
        chk("stall_prog_en", prog_en, 0);
        chk("stall_busy", busy, 1);
        start = 1'($urandom);
        @(negedge prog_clk);
      end
      start = 1'b0;
      chk("word_ready", word_ready, 1);
      word_valid = 1'b1;
      word_data = w;
      for (int i = 0; i < 32; i++) bitq.push_back(w[i]);
      @(negedge prog_clk) word_valid = 1'b0;
      word_data = $urandom;
      for (int c = 1; c <= 32; c++) begin
        if (k == ab_word && c == ab_cyc) begin
          if (rst_hit) begin
            #2 rst = 1'b0;
            #1 chk("async_reset_outputs", {word_ready, prog_dout, prog_en, busy, done, rd_valid, rd_data}, 0);
            flush();
            @(negedge prog_clk) rst = 1'b1;
          end else begin
            abort = 1'b1;
            @(negedge prog_clk) abort = 1'b0;
            chk("abort_prog_en", prog_en, 0);
            chk("abort_busy", busy, 0);
            flush();
          end
          repeat (3) begin
            @(negedge prog_clk);
            chk("no_done_after_abort", {done, busy}, 0);
          end
          return;
        end
        start = (c == 5);
        if (c < 32) @(negedge prog_clk);
      end
      start = 1'b0;
      @(negedge prog_clk);
    end
    chk("done_pulse", done, 1);
    @(negedge prog_clk);
    chk("after_done", {done, busy, prog_en}, 0);
  endtask

  initial begin
    #3 chk("reset_outputs", {word_ready, prog_dout, prog_en, busy, done, rd_valid, rd_data}, 0);
    @(negedge prog_clk);
    @(negedge prog_clk) rst = 1'b1;
    chk("idle_after_reset", {busy, word_ready, prog_en}, 0);
    load(32'hA5C3_0F81, $urandom, 5, -1, 0, 1'b0);
    load(32'h1234_5678, 32'h9ABC_DEF0, 0, -1, 0, 1'b0);
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, -1, 0, 1'b0);
    load($urandom, $urandom, 1, 0, 10, 1'b0);
    load(32'h0F0F_3C3C, $urandom, 0, -1, 0, 1'b0);
    load($urandom, $urandom, 3, 1, 32, 1'b0);
    load($urandom, $urandom, 0, -1, 0, 1'b0);
    load($urandom, $urandom, 2, 0, 17, 1'b1);
    load($urandom, $urandom, 1, -1, 0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(3) == 0)
        load($urandom, $urandom, $urandom_range(5), $urandom_range(1), $urandom_range(32, 1), 1'($urandom));
      else
        load($urandom, $urandom, $urandom_range(5), -1, 0, 1'b0);
    end
    repeat (3) @(negedge prog_clk);
    chk("queues_drained", 64'(chainq.size() + bitq.size() + rdq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cfg_chain_loader.md
CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 32; total configuration chain length in bits; SHALL be a nonzero multiple of 32.
REQ-002 prog_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin a full chain load.
REQ-005 abort  input  1  terminates an in-progress load.
REQ-006 word_data  input  32  configuration word from the host.
REQ-007 word_valid  input  1  word_data is valid.
REQ-008 word_ready  output  1  loader accepts word_data this cycle.
REQ-009 prog_dout  output  1  serial bit driven into the chain's prog_in.
REQ-010 prog_en  output  1  chain shift enable, driven into the chain's prog_en.
REQ-011 prog_din  input  1  chain's prog_out, used for readback.
REQ-012 busy  output  1  a load is in progress.
REQ-013 done  output  1  one-cycle pulse when a load completes.
REQ-014 rd_data  output  32  word reassembled from prog_din bits shifted out of the chain.
REQ-015 rd_valid  output  1  one-cycle pulse when rd_data holds a new word.

Function
REQ-016 States SHALL be IDLE, FETCH, SHIFT, and DONE; busy SHALL be 1 in FETCH, SHIFT, and DONE.
REQ-017 In IDLE, start=1 SHALL move the state to FETCH on the next edge; start SHALL be ignored in all other states.
REQ-018 word_ready SHALL be 1 only in FETCH; a word SHALL transfer on an edge where word_valid and word_ready are both 1.
REQ-019 On transfer the state SHALL go to SHIFT, and from that edge prog_en=1 and prog_dout=word_data[0].
REQ-020 In SHIFT, prog_dout SHALL present word bits LSB-first, one bit per cycle, bit i in the i-th SHIFT cycle, for exactly 32 cycles with prog_en=1 throughout.
REQ-021 After the 32nd bit, if the running bit count equals CHAIN_LEN the state SHALL go to DONE, otherwise back to FETCH.
REQ-022 prog_en SHALL be 0 in IDLE, FETCH, and DONE; a host stall in FETCH therefore freezes the chain.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE with prog_en=0.
REQ-024 After a complete load of a 32-bit chain, the chain register SHALL equal the transferred word: the first bit sent ends in chain bit 0.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge: prog_en=0, no done pulse, bit count cleared, and any partial rd_data word discarded.
REQ-026 abort SHALL take priority over word transfer and over a SHIFT-to-DONE transition occurring on the same edge.
REQ-027 The bit counter SHALL be wide enough for CHAIN_LEN without wrap and SHALL clear on every entry to IDLE.
REQ-028 prog_dout SHALL be 0 whenever prog_en is 0.

Reset
REQ-029 When rst=0: state=IDLE; word_ready, prog_dout, prog_en, busy, done, and rd_valid SHALL be 0; rd_data=0; all counters and shift registers SHALL be 0.
REQ-030 Reset assertion mid-load SHALL abandon the load immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro CFG_READBACK_EN SHALL, when defined, enable readback.
REQ-032 With CFG_READBACK_EN, prog_din SHALL be sampled on every edge where registered prog_en=1, capturing the chain's pre-shift bit 0.
REQ-033 With CFG_READBACK_EN, the k-th sampled bit of each 32-bit group SHALL go to rd_data[k], and rd_valid SHALL pulse on the cycle after the 32nd bit of the group.
REQ-034 Without CFG_READBACK_EN, rd_data SHALL be 0, rd_valid SHALL be 0, prog_din SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-035 Scenario: CHAIN_LEN=32, start, word 0xA5C3_0F81 -> 32 prog_en cycles with prog_dout sequence 1,0,0,0,0,0,0,1,...; attached chain register = 0xA5C30F81; done pulse once.
REQ-036 Scenario: CHAIN_LEN=64, word_valid withheld 5 cycles between words -> prog_en=0 for those 5 cycles, 64 total enabled cycles, done only after the second word.
REQ-037 Scenario: CFG_READBACK_EN, chain preloaded 0x1234_5678, new load 0xFFFF_FFFF -> rd_data=0x12345678 with rd_valid pulse; chain=0xFFFFFFFF.
REQ-038 Scenario: abort asserted in the 10th SHIFT cycle -> prog_en=0 next cycle, busy=0, no done; a new start then loads correctly from bit 0.
REQ-039 Scenario: rst=0 pulse mid-SHIFT without a clock edge -> all outputs 0 immediately; start during busy -> ignored.
